// File: rtl/rgmii_rx_delay_cal.sv
// rgmii_rx_delay_cal: RX input-delay sweep, eye scoring on idle nibbles, centre load (optional RGMII_DLY_READBACK_EN readback check)
module rgmii_rx_delay_cal #(
  parameter int TAP_WIDTH     = 9,
  parameter int TAP_MAX       = 511,
  parameter int TAP_STEP      = 8,
  parameter int VTC_WAIT      = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [TAP_WIDTH-1:0] lock_tap,
  output logic [TAP_WIDTH:0]   eye_width,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_er,
  output logic                 dly_en,
  output logic                 dly_inc,
  output logic                 dly_load,
  output logic                 dly_en_vtc,
  output logic [TAP_WIDTH-1:0] dly_cnt_value_in,
  input  logic [TAP_WIDTH-1:0] dly_cnt_value_out
);
  localparam int W1 = TAP_WIDTH + 1;
  localparam int CW = $clog2(VTC_WAIT + SETTLE_CYCLES + SAMPLE_CYCLES + 1);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, VTC_OFF, LOAD, SETTLE, SAMPLE, EVAL, NEXT, FINAL, FSETTLE} state_t;
  state_t               state_q;
  logic                 busy_q, done_q, fail_q, load_q, vtc_q;
  logic [TAP_WIDTH-1:0] tap_q, cnt_in_q, lock_q, cur_start_q, best_start_q, cur_start_d, fin_d;
  logic [W1-1:0]        eye_q, cur_len_q, best_len_q, cur_len_d, tap_nx;
  logic [CW-1:0]        cnt_q;
  logic [SW-1:0]        idle_q, mis_q;
  logic                 pass, bad;
  assign busy             = busy_q;
  assign done             = done_q;
  assign fail             = fail_q;
  assign lock_tap         = lock_q;
  assign eye_width        = eye_q;
  assign dly_en           = 1'b0;
  assign dly_inc          = 1'b0;
  assign dly_load         = load_q;
  assign dly_en_vtc       = vtc_q;
  assign dly_cnt_value_in = cnt_in_q;
`ifndef RGMII_DLY_READBACK_EN
  logic unused_readback;
  assign unused_readback = ^dly_cnt_value_out;
`endif
  // Run tracking, next sample point and eye centre
  always_comb begin
    bad         = gmii_rx_er || (gmii_rxd[3:0] != gmii_rxd[7:4]);
    pass        = (mis_q == '0) && (idle_q >= SW'(SAMPLE_CYCLES / 2));
    cur_len_d   = pass ? cur_len_q + 1'b1 : '0;
    cur_start_d = (pass && cur_len_q == '0) ? tap_q : cur_start_q;
    tap_nx      = {1'b0, tap_q} + W1'(TAP_STEP);
    fin_d       = (best_len_q == '0) ? '0 :
                  best_start_q + TAP_WIDTH'(((best_len_q - 1'b1) * W1'(TAP_STEP)) >> 1);
  end
  // Calibration sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      load_q       <= 1'b0;
      vtc_q        <= 1'b1;
      tap_q        <= '0;
      cnt_in_q     <= '0;
      lock_q       <= '0;
      eye_q        <= '0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      mis_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          busy_q       <= 1'b1;
          done_q       <= 1'b0;
          fail_q       <= 1'b0;
          vtc_q        <= 1'b0;
          tap_q        <= '0;
          cur_len_q    <= '0;
          cur_start_q  <= '0;
          best_len_q   <= '0;
          best_start_q <= '0;
          cnt_q        <= CW'(VTC_WAIT - 1);
          state_q      <= VTC_OFF;
        end
        VTC_OFF: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          load_q   <= 1'b1;
          cnt_in_q <= tap_q;
          state_q  <= LOAD;
        end
        LOAD: begin
          load_q  <= 1'b0;
          cnt_q   <= CW'(SETTLE_CYCLES - 1);
          state_q <= SETTLE;
        end
        SETTLE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
`ifdef RGMII_DLY_READBACK_EN
        else if (dly_cnt_value_out != cnt_in_q) begin
          fail_q   <= 1'b1;
          load_q   <= 1'b1;
          cnt_in_q <= '0;
          state_q  <= FINAL;
        end
`endif
        else begin
          idle_q  <= '0;
          mis_q   <= '0;
          cnt_q   <= CW'(SAMPLE_CYCLES - 1);
          state_q <= SAMPLE;
        end
        SAMPLE: begin
          if (!gmii_rx_dv && idle_q != '1) idle_q <= idle_q + 1'b1;
          if (!gmii_rx_dv && bad && mis_q != '1) mis_q <= mis_q + 1'b1;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else state_q <= EVAL;
        end
        EVAL: begin
          cur_len_q   <= cur_len_d;
          cur_start_q <= cur_start_d;
          if (cur_len_d > best_len_q) begin
            best_len_q   <= cur_len_d;
            best_start_q <= cur_start_d;
          end
          state_q <= NEXT;
        end
        NEXT: begin
          load_q <= 1'b1;
          if (tap_nx > W1'(TAP_MAX)) begin
            cnt_in_q <= fin_d;
            fail_q   <= (best_len_q == '0);
            state_q  <= FINAL;
          end else begin
            tap_q    <= tap_nx[TAP_WIDTH-1:0];
            cnt_in_q <= tap_nx[TAP_WIDTH-1:0];
            state_q  <= LOAD;
          end
        end
        FINAL: begin
          load_q  <= 1'b0;
          cnt_q   <= CW'(SETTLE_CYCLES - 1);
          state_q <= FSETTLE;
        end
        FSETTLE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          vtc_q   <= 1'b1;
          lock_q  <= cnt_in_q;
          eye_q   <= best_len_q;
          done_q  <= !fail_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// tb_rgmii_rx_delay_cal: randomized sweep scenarios scored against an eye-search model via a scoreboard
module tb_rgmii_rx_delay_cal;
  localparam int TW = 9, STEP = 8, SET = 4, SMP = 32, BUDGET = 4000;
  typedef struct packed {
    logic       done;
    logic       fail;
    logic [8:0] lock;
    logic [9:0] eye;
    logic [7:0] loads;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, fail, dly_en, dly_inc, dly_load, dly_en_vtc;
  logic [TW-1:0] lock_tap, dly_cnt_value_in, dly_cnt_value_out;
  logic [TW:0] eye_width;
  logic [7:0] gmii_rxd = 0;
  logic gmii_rx_dv = 0, gmii_rx_er = 0;
  logic [TW-1:0] line_q = 0;
  bit stuck = 0;
  int mode [64];
  int checks = 0, passes = 0;
  exp_t sbq [$];
  rgmii_rx_delay_cal #(.TAP_WIDTH(TW), .TAP_MAX(511), .TAP_STEP(STEP), .VTC_WAIT(4),
                       .SETTLE_CYCLES(SET), .SAMPLE_CYCLES(SMP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .lock_tap(lock_tap), .eye_width(eye_width), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .dly_en(dly_en), .dly_inc(dly_inc), .dly_load(dly_load),
    .dly_en_vtc(dly_en_vtc), .dly_cnt_value_in(dly_cnt_value_in), .dly_cnt_value_out(dly_cnt_value_out));
  always #5 clk = ~clk;
  always @(posedge clk) if (dly_load) line_q <= dly_cnt_value_in;
  assign dly_cnt_value_out = stuck ? '0 : line_q;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d want %0d", nm, act, req);
  endtask
  function automatic exp_t model(input int neval, input bit abort);
    exp_t e;
    int bl = 0, bs = 0, rl = 0, rs = 0;
    for (int i = 0; i < neval; i++)
      if (mode[i] == 0 || mode[i] == 3) begin
        if (rl == 0) rs = i * STEP;
        rl++;
        if (rl > bl) begin bl = rl; bs = rs; end
      end else rl = 0;
    e.fail  = abort || bl == 0;
    e.done  = !e.fail;
    e.lock  = e.fail ? 9'd0 : 9'(bs + ((bl - 1) * STEP) / 2);
    e.eye   = 10'(bl);
    e.loads = 8'(neval + (abort ? 2 : 1));
    return e;
  endfunction
  // Line stimulus: 0 clean idle, 1 corrupted idle, 2 mostly dv (too few idles), 3 exactly half idle
  initial begin
    int ph = 0;
    logic [3:0] n;
    forever begin
      @(negedge clk);
      ph++;
      n = 4'($urandom_range(15));
      gmii_rxd = {n, n};
      gmii_rx_er = 0;
      case (mode[line_q[8:3]])
        0: gmii_rx_dv = ($urandom_range(15) == 0);
        1: begin
          gmii_rx_dv = ($urandom_range(15) == 0);
          if ($urandom_range(1) == 1) gmii_rx_er = 1;
          else gmii_rxd = {n ^ 4'($urandom_range(1, 15)), n};
        end
        2: gmii_rx_dv = (ph % 4 != 0);
        default: gmii_rx_dv = ph[0];
      endcase
    end
  end
  // Monitor: protocol invariants and end-of-calibration results against the scoreboard
  initial begin
    bit pb = 0, pl = 0;
    int loads = 0;
    logic [TW-1:0] first = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !pb) loads = 0;
      if (dly_load) begin
        chk("load_vtc_low", dly_en_vtc, 0);
        chk("load_single", pl, 0);
        if (loads == 0) first = dly_cnt_value_in;
        loads++;
      end
      if (pb && !busy && !rst) begin
        if (sbq.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
          e = sbq.pop_front();
          chk("done", done, e.done);
          chk("fail", fail, e.fail);
          chk("lock_tap", lock_tap, e.lock);
          chk("eye_width", eye_width, e.eye);
          chk("final_load", dly_cnt_value_in, e.lock);
          chk("vtc_back", dly_en_vtc, 1);
          chk("load_count", loads, e.loads);
          chk("first_tap", first, 0);
          chk("en_inc", {dly_en, dly_inc}, 0);
        end
      end
      pb = busy && !rst;
      pl = dly_load;
    end
  end
  task automatic sweep(input int neval, input bit abort, input bit extra);
    exp_t e;
    int n = 0;
    e = model(neval, abort);
    sbq.push_back(e);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("busy_rise", busy, 1);
    chk("vtc_fall", dly_en_vtc, 0);
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
      start = extra && n == 1500;
      if (extra && n == 1501) chk("busy_held", busy, 1);
    end
    start = 0;
    chk("finished", !busy, 1);
    repeat (3) @(negedge clk);
    chk("done_sticky", done, e.done);
    chk("fail_sticky", fail, e.fail);
  endtask
  initial begin
    int n;
    foreach (mode[i]) mode[i] = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fail", fail, 0);
    chk("rst_load", dly_load, 0); chk("rst_en", dly_en, 0); chk("rst_inc", dly_inc, 0);
    chk("rst_vtc", dly_en_vtc, 1); chk("rst_cnt_in", dly_cnt_value_in, 0);
    chk("rst_lock", lock_tap, 0); chk("rst_eye", eye_width, 0);
    @(posedge clk); #2 rst = 0;
    sweep(64, 0, 0);
    foreach (mode[i]) mode[i] = (i >= 8 && i <= 24) ? (i % 2 ? 3 : 0) : (i % 2 ? 1 : 2);
    sweep(64, 0, 0);
    foreach (mode[i]) mode[i] = 1 + $urandom_range(1);
    sweep(64, 0, 0);
    foreach (mode[i]) mode[i] = (i <= 7 || (i >= 25 && i <= 32)) ? 0 : 1;
    sweep(64, 0, 1);
    foreach (mode[i]) mode[i] = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (!(dly_load && dly_cnt_value_in == 96) && n < BUDGET) begin @(negedge clk); n++; end
    chk("reach_tap96", dly_cnt_value_in, 96);
    repeat (SET + 6) @(negedge clk);
    @(posedge clk); #2 rst = 1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_vtc", dly_en_vtc, 1);
    chk("mid_rst_load", dly_load, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_lock", lock_tap, 0); chk("mid_rst_eye", eye_width, 0);
    @(posedge clk); #2 rst = 0;
    sweep(64, 0, 0);
    foreach (mode[i]) mode[i] = $urandom_range(3);
    mode[0] = 0;
    stuck = 1;
`ifdef RGMII_DLY_READBACK_EN
    sweep(1, 1, 0);
`else
    sweep(64, 0, 0);
`endif
    stuck = 0;
    for (int r = 0; r < 2; r++) begin
      foreach (mode[i]) mode[i] = ($urandom_range(3) == 0) ? 1 + $urandom_range(1) : 3 * $urandom_range(1);
      sweep(64, 0, 0);
    end
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
